fetch_unit: RTL

Instruction-fetch stage of the pipelined 16-bit CPU. Owns the program counter, drives the instruction-memory read handshake, and loads the IF/ID pipeline register whose instruction word feeds the control unit and register-file read in ID. Handles load-use stalls by buffering one fetched word, and branch/jump redirects by flushing IF/ID and discarding any in-flight fetch.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Constants shared by the CPU pipeline stages that touch instruction words.
//   WORD_SIZE : instruction and address width of the 16-bit CPU.
//   NOP       : ISA encoding of the no-operation instruction. IF/ID is loaded
//               with it on reset and on a flush so that ID decodes a harmless
//               instruction.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [WORD_SIZE-1:0] NOP = 16'hF01C;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_unit_buffer
//   One-entry hold register with a valid flag. The fetch stage parks a word here
//   when the word returns from memory while ID is stalled. Kept as its own
//   block so that a later prefetch queue can reuse it.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   i_load             capture i_instr/i_pc1 and mark the entry valid
//   i_clear            invalidate the entry (takes priority over i_load)
//   i_instr, i_pc1     word to park and the address of that word plus one
//   o_instr, o_pc1     parked word and its address plus one
//   o_valid            the entry holds a word
// -----------------------------------------------------------------------------
module fetch_unit_buffer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [WORD_SIZE-1:0] i_instr,
  input  logic [WORD_SIZE-1:0] i_pc1,
  output logic [WORD_SIZE-1:0] o_instr,
  output logic [WORD_SIZE-1:0] o_pc1,
  output logic                 o_valid
);

  logic                 r_valid;
  logic [WORD_SIZE-1:0] r_instr;
  logic [WORD_SIZE-1:0] r_pc1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // NOTE: the data fields have no reset. r_valid qualifies them, so a reset
  // would only add reset fan-out and would not change behaviour.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_instr <= i_instr;
      r_pc1   <= i_pc1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc1   = r_pc1;
  assign o_valid = r_valid;

endmodule : fetch_unit_buffer

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. It owns the PC, runs the instruction-memory read
//   handshake and loads the IF/ID register. A word that arrives while ID is
//   stalled is parked in a one-entry buffer. A branch or jump flush redirects
//   the PC, clears IF/ID and throws away any fetch still in flight.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   i_readM, i_address   memory read request and its address (both registered)
//   i_data, i_inputReady returned word and its one-cycle valid pulse
//   stall                ID is stalled, so hold the IF/ID contents
//   flush, redirect_pc   redirect fetch to redirect_pc, squash IF/ID
//   if_id_instr/pc1/valid IF/ID register: word, its address + 1, real-word flag
//   fetch_count          number of words delivered to IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                   WORD_SIZE = fetch_unit_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pc1,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] fetch_count
);

  import fetch_unit_pkg::NOP;

  // GAP : no request, this cycle separates two requests
  // REQ : request outstanding, the result is wanted
  // DROP: request outstanding, the result is discarded (flushed meanwhile)
  // HOLD: no request, one word parked until the stall releases
  typedef enum logic [1:0] {
    GAP  = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [WORD_SIZE-1:0] ONE     = WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] NOP_W   = WORD_SIZE'(NOP);

  state_e               r_state;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_req_addr;
  logic [WORD_SIZE-1:0] r_if_id_instr;
  logic [WORD_SIZE-1:0] r_if_id_pc1;
  logic                 r_if_id_valid;
  logic [WORD_SIZE-1:0] r_fetch_count;

  logic [WORD_SIZE-1:0] w_req_next;
  logic                 w_hold_load;
  logic                 w_hold_clear;
  logic [WORD_SIZE-1:0] w_hold_instr;
  logic [WORD_SIZE-1:0] w_hold_pc1;
  logic                 w_hold_valid;

  // Address of the word currently being fetched, plus one. The sum wraps at 2^16.
  assign w_req_next = r_req_addr + ONE;

  // The word is parked when it arrives while ID is stalled. A flush wins over
  // the arriving data.
  assign w_hold_load  = (r_state == REQ) && i_inputReady && stall && !flush;
  assign w_hold_clear = flush || ((r_state == HOLD) && !stall);

  fetch_unit_buffer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_instr (i_data),
    .i_pc1   (w_req_next),
    .o_instr (w_hold_instr),
    .o_pc1   (w_hold_pc1),
    .o_valid (w_hold_valid)
  );

  // NOTE: every register in this block uses non-blocking assignments. The next
  // state, the PC and IF/ID all read the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= GAP;
      r_pc          <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_if_id_instr <= NOP_W;
      r_if_id_pc1   <= '0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else if (flush) begin
      r_pc          <= redirect_pc;
      r_if_id_instr <= NOP_W;
      r_if_id_pc1   <= '0;
      r_if_id_valid <= 1'b0;
      // A read still open on the bus must be allowed to finish. Its response
      // is then thrown away in DROP. r_req_addr stays put because the address
      // has to be stable while i_readM is high.
      if (((r_state == REQ) || (r_state == DROP)) && !i_inputReady) begin
        r_state <= DROP;
      end else begin
        r_state <= GAP;
      end
    end else begin
      unique case (r_state)
        GAP: begin
          r_req_addr <= r_pc;
          r_state    <= REQ;
        end
        REQ: begin
          if (i_inputReady) begin
            r_pc <= w_req_next;
            if (stall) begin
              r_state <= HOLD;
            end else begin
              r_if_id_instr <= i_data;
              r_if_id_pc1   <= w_req_next;
              r_if_id_valid <= 1'b1;
              r_fetch_count <= r_fetch_count + ONE;
              r_state       <= GAP;
            end
          end
        end
        HOLD: begin
          // The request for the next word goes out in the same edge that
          // delivers the parked word. No GAP is needed because i_readM was
          // already low in HOLD.
          if (!stall && w_hold_valid) begin
            r_if_id_instr <= w_hold_instr;
            r_if_id_pc1   <= w_hold_pc1;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + ONE;
            r_req_addr    <= r_pc;
            r_state       <= REQ;
          end
        end
        DROP: begin
          if (i_inputReady) begin
            r_state <= GAP;
          end
        end
        default: r_state <= GAP;
      endcase
    end
  end

  // Both signals are decoded from registers only, so nothing combinational
  // runs from the inputs to the memory request.
  assign i_readM     = (r_state == REQ) || (r_state == DROP);
  assign i_address   = r_req_addr;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc1   = r_if_id_pc1;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;

endmodule : fetch_unit
